// File: rtl/mips_pkg.sv
// Shared MIPS core types: write-back select encodings, the memory-stage FSM
// states and the MEM/WB slot record.
package mips_pkg;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_ILL = 2'b11;

   typedef enum logic {
      IDLE,
      WAIT
   } mem_state_t;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [31:0] alu_result;
      logic [31:0] mem_data;
      logic [31:0] pc_plus4;
      logic [4:0]  dest_reg;
      logic [1:0]  sel;
      logic        addr_err;
      logic        bus_err;
   } mem_wb_slot_t;

   // A bubble keeps the data fields and clears everything that has an effect.
   function automatic mem_wb_slot_t make_bubble(input mem_wb_slot_t s);
      mem_wb_slot_t b;
      b           = s;
      b.valid     = 1'b0;
      b.reg_write = 1'b0;
      b.addr_err  = 1'b0;
      b.bus_err   = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the data-memory port: clear, enable, and a flag
// raised when the count reaches COUNT_MAX.
module mem_wait_timer #(
   parameter int COUNT_MAX = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam int W = (COUNT_MAX > 0) ? $clog2(COUNT_MAX + 1) : 1;

   logic [W-1:0] count;

   // NOTE: non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + W'(1);
      end
   end

   assign terminal = (count == W'(COUNT_MAX));

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory-access stage and MEM/WB register: word load/store over a
// ready/ack port with stall, timeout, misalignment and flush handling.
module mem_wb_stage
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [31:0] pc_plus4,
   input  logic [4:0]  dest_reg,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        reg_write,
   input  logic [1:0]  wb_sel,
   input  logic        flush,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [31:0] wb_alu_result,
   output logic [31:0] wb_mem_data,
   output logic [31:0] wb_pc_plus4,
   output logic        wb_sel_0,
   output logic        wb_sel_1,
   output logic [4:0]  wb_dest_reg,
   output logic        addr_err,
   output logic        bus_err
);

   mem_state_t   state, state_next;
   mem_wb_slot_t slot, slot_next;

   logic mem_access;
   logic aligned;
   logic mem_op;
   logic misaligned;
   logic terminal;
   logic timeout;

   assign mem_access = in_valid & (mem_read | mem_write);
   assign aligned    = (alu_result[1:0] == 2'b00);
   assign mem_op     = mem_access & aligned;
   assign misaligned = mem_access & ~aligned;

   // rst_n gates the request so a reset mid-access drops it immediately.
   assign dmem_req   = mem_op & ~flush & rst_n;
   assign dmem_we    = mem_write;
   assign dmem_addr  = {alu_result[31:2], 2'b00};
   assign dmem_wdata = store_data;

   assign timeout = (state == WAIT) & terminal & dmem_req & ~dmem_ack;
   assign stall   = dmem_req & ~dmem_ack & ~timeout;

   mem_wait_timer #(
      .COUNT_MAX (TIMEOUT_CYCLES - 1)
   ) u_wait_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (state == IDLE),
      .enable   (state == WAIT),
      .terminal (terminal)
   );

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      slot_next  = make_bubble(slot);

      case (state)
         IDLE:    if (dmem_req & ~dmem_ack) state_next = WAIT;
         WAIT:    if (~dmem_req | dmem_ack | timeout) state_next = IDLE;
         default: state_next = IDLE;
      endcase

      if (!flush && !stall) begin
         slot_next.valid      = in_valid;
         slot_next.reg_write  = in_valid & reg_write & (wb_sel != WB_ILL)
                                & ~misaligned & ~timeout;
         slot_next.alu_result = alu_result;
         slot_next.pc_plus4   = pc_plus4;
         slot_next.dest_reg   = dest_reg;
         slot_next.sel        = (wb_sel == WB_ILL) ? WB_ALU : wb_sel;
         slot_next.addr_err   = misaligned;
         slot_next.bus_err    = timeout;
         // Load data only moves on a completed read; everything else holds it.
         if (mem_op & mem_read & dmem_ack) begin
            slot_next.mem_data = dmem_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         slot  <= '0;
      end else begin
         state <= state_next;
         slot  <= slot_next;
      end
   end

   assign wb_valid      = slot.valid;
   assign wb_reg_write  = slot.reg_write;
   assign wb_alu_result = slot.alu_result;
   assign wb_mem_data   = slot.mem_data;
   assign wb_pc_plus4   = slot.pc_plus4;
   assign wb_sel_0      = slot.sel[0];
   assign wb_sel_1      = slot.sel[1];
   assign wb_dest_reg   = slot.dest_reg;
   assign addr_err      = slot.addr_err;
   assign bus_err       = slot.bus_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vectors, literal checks and
// a cycle-by-cycle behavioural model of the stage.
module tb_mem_wb_stage;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic [31:0] pc_plus4;
   logic [4:0]  dest_reg;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic [1:0]  wb_sel;
   logic        flush;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        stall;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [31:0] wb_alu_result;
   logic [31:0] wb_mem_data;
   logic [31:0] wb_pc_plus4;
   logic        wb_sel_0;
   logic        wb_sel_1;
   logic [4:0]  wb_dest_reg;
   logic        addr_err;
   logic        bus_err;

   int n_cmp = 0;
   int n_err = 0;

   mem_wb_stage #(.TIMEOUT_CYCLES(T)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .alu_result    (alu_result),
      .store_data    (store_data),
      .pc_plus4      (pc_plus4),
      .dest_reg      (dest_reg),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .reg_write     (reg_write),
      .wb_sel        (wb_sel),
      .flush         (flush),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_rdata    (dmem_rdata),
      .dmem_ack      (dmem_ack),
      .stall         (stall),
      .wb_valid      (wb_valid),
      .wb_reg_write  (wb_reg_write),
      .wb_alu_result (wb_alu_result),
      .wb_mem_data   (wb_mem_data),
      .wb_pc_plus4   (wb_pc_plus4),
      .wb_sel_0      (wb_sel_0),
      .wb_sel_1      (wb_sel_1),
      .wb_dest_reg   (wb_dest_reg),
      .addr_err      (addr_err),
      .bus_err       (bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // age = number of consecutive cycles the current access has waited unacked.
   bit          model_live = 1'b0;
   int          age;
   logic        e_valid, e_rw, e_aerr, e_berr;
   logic [31:0] e_alu, e_mem, e_pc;
   logic [4:0]  e_dest;
   logic [1:0]  e_sel;

   always @(posedge clk) begin : model_update
      logic attempt, ok_addr, req, tout, waiting;
      if (!rst_n) begin
         model_live <= 1'b1;
         age     <= 0;
         e_valid <= 1'b0; e_rw <= 1'b0; e_aerr <= 1'b0; e_berr <= 1'b0;
         e_alu   <= '0;   e_mem <= '0;  e_pc   <= '0;   e_dest <= '0; e_sel <= '0;
      end else begin
         attempt = in_valid & (mem_read | mem_write);
         ok_addr = (alu_result % 4) == 0;
         req     = attempt & ok_addr & !flush;
         tout    = req & !dmem_ack & (age == T);
         waiting = req & !dmem_ack & !tout;
         age    <= waiting ? age + 1 : 0;
         if (flush || waiting) begin
            e_valid <= 1'b0; e_rw <= 1'b0; e_aerr <= 1'b0; e_berr <= 1'b0;
         end else begin
            e_valid <= in_valid;
            e_rw    <= in_valid & reg_write & (wb_sel != 2'd3) & !(attempt & !ok_addr) & !tout;
            e_alu   <= alu_result;
            e_pc    <= pc_plus4;
            e_dest  <= dest_reg;
            e_sel   <= (wb_sel == 2'd3) ? 2'd0 : wb_sel;
            e_aerr  <= attempt & !ok_addr;
            e_berr  <= tout;
            if (req && dmem_ack && mem_read) e_mem <= dmem_rdata;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin : compare
      logic req_e, stall_e;
      if (model_live) begin
         req_e   = rst_n & in_valid & (mem_read | mem_write) & ((alu_result % 4) == 0) & !flush;
         stall_e = req_e & !dmem_ack & (age != T);
         check("dmem_req", dmem_req, req_e);
         check("stall", stall, stall_e);
         if (req_e) begin
            check("dmem_addr", dmem_addr, alu_result & 32'hFFFF_FFFC);
            check("dmem_we", dmem_we, mem_write);
            check("dmem_wdata", dmem_wdata, store_data);
         end
         check("wb_valid", wb_valid, e_valid);
         check("wb_reg_write", wb_reg_write, e_rw);
         check("wb_alu_result", wb_alu_result, e_alu);
         check("wb_mem_data", wb_mem_data, e_mem);
         check("wb_pc_plus4", wb_pc_plus4, e_pc);
         check("wb_dest_reg", wb_dest_reg, e_dest);
         check("wb_sel_0", wb_sel_0, e_sel[0]);
         check("wb_sel_1", wb_sel_1, e_sel[1]);
         check("addr_err", addr_err, e_aerr);
         check("bus_err", bus_err, e_berr);
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle_in();
      in_valid = 1'b0; alu_result = '0; store_data = '0; pc_plus4 = '0;
      dest_reg = '0;   mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
      wb_sel = 2'b00;  flush = 1'b0;    dmem_ack = 1'b0;  dmem_rdata = '0;
   endtask

   task automatic op(input logic [31:0] a, input logic [31:0] sd, input logic [31:0] pc,
                     input logic [4:0] dr, input logic mr, input logic mw,
                     input logic rw, input logic [1:0] sel);
      in_valid = 1'b1; alu_result = a; store_data = sd; pc_plus4 = pc;
      dest_reg = dr; mem_read = mr; mem_write = mw; reg_write = rw; wb_sel = sel;
      flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int req_cnt, stall_cnt;
      bit got_berr;

      idle_in();
      rst_n = 1'b0;
      tick(); tick();
      check("rst wb_valid", wb_valid, 1'b0);
      check("rst wb_alu_result", wb_alu_result, 32'h0);
      check("rst wb_dest_reg", wb_dest_reg, 5'd0);
      rst_n = 1'b1;

      // ADD
      op(32'h0000_0010, 32'h0, 32'h0040_0004, 5'd8, 1'b0, 1'b0, 1'b1, 2'b00);
      #1 check("add stall", stall, 1'b0);
      tick();
      check("add wb_valid", wb_valid, 1'b1);
      check("add wb_reg_write", wb_reg_write, 1'b1);
      check("add wb_alu_result", wb_alu_result, 32'h10);
      check("add wb_dest_reg", wb_dest_reg, 5'd8);
      check("add sel", {wb_sel_1, wb_sel_0}, 2'b00);

      // LW with ack on the third request cycle
      op(32'h0000_0100, 32'h0, 32'h0040_0008, 5'd9, 1'b1, 1'b0, 1'b1, 2'b01);
      req_cnt = 0; stall_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         dmem_ack   = (i == 2);
         dmem_rdata = (i == 2) ? 32'hDEAD_BEEF : 32'h0;
         #1;
         req_cnt   += int'(dmem_req);
         stall_cnt += int'(stall);
         tick();
      end
      check("lw req cycles", req_cnt, 3);
      check("lw stall cycles", stall_cnt, 2);
      check("lw wb_mem_data", wb_mem_data, 32'hDEAD_BEEF);
      check("lw sel_0", wb_sel_0, 1'b1);
      check("lw wb_valid", wb_valid, 1'b1);

      // JAL
      op(32'h0, 32'h0, 32'h0040_0008, 5'd31, 1'b0, 1'b0, 1'b1, 2'b10);
      tick();
      check("jal wb_pc_plus4", wb_pc_plus4, 32'h0040_0008);
      check("jal sel_1", wb_sel_1, 1'b1);
      check("jal wb_dest_reg", wb_dest_reg, 5'd31);
      check("jal mem_data held", wb_mem_data, 32'hDEAD_BEEF);

      // illegal wb_sel
      op(32'h55, 32'h0, 32'h0040_000C, 5'd3, 1'b0, 1'b0, 1'b1, 2'b11);
      tick();
      check("sel11 wb_reg_write", wb_reg_write, 1'b0);
      check("sel11 sel", {wb_sel_1, wb_sel_0}, 2'b00);

      // misaligned SW then misaligned LW
      op(32'h0000_0103, 32'hCAFE_0001, 32'h0040_0010, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00);
      #1 check("sw103 dmem_req", dmem_req, 1'b0);
      check("sw103 stall", stall, 1'b0);
      tick();
      check("sw103 addr_err", addr_err, 1'b1);
      check("sw103 wb_reg_write", wb_reg_write, 1'b0);
      op(32'h0000_0102, 32'h0, 32'h0040_0014, 5'd4, 1'b1, 1'b0, 1'b1, 2'b01);
      tick();
      check("lw102 wb_reg_write", wb_reg_write, 1'b0);
      idle_in();
      tick();
      check("addr_err pulse end", addr_err, 1'b0);

      // SW never acknowledged
      op(32'h0000_0200, 32'h1234_5678, 32'h0040_0018, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00);
      stall_cnt = 0; got_berr = 1'b0;
      for (int i = 0; i < 12 && !got_berr; i++) begin
         #1 stall_cnt += int'(stall);
         tick();
         if (bus_err) got_berr = 1'b1;
      end
      check("timeout bus_err seen", got_berr, 1'b1);
      check("timeout stall cycles", stall_cnt, T);
      check("timeout wb_reg_write", wb_reg_write, 1'b0);

      // zero-wait LW right after the timeout, then back-to-back
      op(32'h0000_0204, 32'h0, 32'h0040_001C, 5'd5, 1'b1, 1'b0, 1'b1, 2'b01);
      dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_0001;
      #1 check("lw0 stall", stall, 1'b0);
      tick();
      check("lw0 wb_mem_data", wb_mem_data, 32'hA5A5_0001);
      op(32'h0000_0208, 32'h0, 32'h0040_0020, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01);
      dmem_ack = 1'b1; dmem_rdata = 32'h0000_0B2B;
      #1 check("b2b dmem_req", dmem_req, 1'b1);
      tick();
      check("b2b wb_mem_data", wb_mem_data, 32'h0000_0B2B);

      // flush during LW wait
      op(32'h0000_0300, 32'h0, 32'h0040_0024, 5'd7, 1'b1, 1'b0, 1'b1, 2'b01);
      tick(); tick();
      flush = 1'b1;
      #1 check("flush dmem_req", dmem_req, 1'b0);
      check("flush stall", stall, 1'b0);
      tick();
      check("flush wb_valid", wb_valid, 1'b0);
      check("flush mem_data held", wb_mem_data, 32'h0000_0B2B);

      // flush with ack in the same cycle
      op(32'h0000_0304, 32'h0, 32'h0040_0028, 5'd7, 1'b1, 1'b0, 1'b1, 2'b01);
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_0000; flush = 1'b1;
      tick();
      check("flush+ack wb_valid", wb_valid, 1'b0);
      check("flush+ack mem_data", wb_mem_data, 32'h0000_0B2B);

      // reset during WAIT
      op(32'h0000_0400, 32'h0, 32'h0040_002C, 5'd10, 1'b1, 1'b0, 1'b1, 2'b01);
      tick(); tick();
      rst_n = 1'b0;
      #1 check("rst dmem_req", dmem_req, 1'b0);
      check("rst stall", stall, 1'b0);
      tick();
      check("rst2 wb_mem_data", wb_mem_data, 32'h0);
      check("rst2 wb_pc_plus4", wb_pc_plus4, 32'h0);
      check("rst2 wb_valid", wb_valid, 1'b0);
      rst_n = 1'b1;
      op(32'h0000_0400, 32'h0, 32'h0040_002C, 5'd10, 1'b1, 1'b0, 1'b1, 2'b01);
      for (int i = 0; i < 2; i++) begin
         dmem_ack   = (i == 1);
         dmem_rdata = 32'h1234_5678;
         tick();
      end
      check("post-rst lw wb_mem_data", wb_mem_data, 32'h1234_5678);
      check("post-rst lw wb_valid", wb_valid, 1'b1);
      check("post-rst lw wb_dest_reg", wb_dest_reg, 5'd10);

      idle_in();
      tick(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
